// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline stage register with a 2-entry skid buffer.
// The main register drives the output side. The skid register absorbs the one
// beat that arrives in the same cycle downstream stalls. This keeps in_ready a
// pure flop decode and still sustains 1 beat/cycle. A flush inserts a bubble,
// which is an all-zero NOP payload.
// Optional feature: define PIPE_STAGE_STATS_EN to add the saturating
// stall_cnt / flush_cnt statistics ports.
module pipe_stage_skid #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   // The state encoding equals the number of held entries, so occupancy is the state itself.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_fire, out_fire;

   // The output side is driven straight from flops. Main is kept at zero while
   // EMPTY, so out_data reads 0 whenever out_valid is low.
   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // Next-state and storage update. A flush overrides every handshake.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_d  = in_data;
                  state_d = BUSY;
               end
            end
            BUSY: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  skid_d  = in_data;
                  state_d = FULL;
               end else if (out_fire) begin
                  main_d  = '0;
                  state_d = EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only the output side can move.
               if (out_fire) begin
                  main_d  = skid_q;
                  skid_d  = '0;
                  state_d = BUSY;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = '0;
               skid_d  = '0;
            end
         endcase
      end
   end

   // State and payload registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

`ifdef PIPE_STAGE_STATS_EN
   // Saturating statistics counters. Only reset clears them; a flush does not.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
         if (flush && (flush_cnt != {CNT_W{1'b1}}))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed vectors for pipe_stage_skid.
// A queue-based model predicts the outputs and is compared on every cycle.
// Literal expectations in the stimulus pin the model down.
module tb_pipe_stage_skid;
   localparam int DATA_W = 64;
   localparam int CNT_W  = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   int errors = 0;
   int checks = 0;

   pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy)
`ifdef PIPE_STAGE_STATS_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

`ifndef PIPE_STAGE_STATS_EN
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an ordered list of held beats plus counters. Each clock edge
   // applies the handshake rules to it, and the outputs are checked 1ns later.
   logic [DATA_W-1:0] mq[$];
   int stall_m = 0;
   int flush_m = 0;

   always begin
      @(posedge clk);
      if (reset) begin
         mq.delete();
         stall_m = 0;
         flush_m = 0;
      end else begin
         automatic int  occ = mq.size();
         automatic bit  ov  = (occ > 0);
         automatic bit  of  = ov && out_ready;
         automatic bit  inf = in_valid && (occ < 2);
         if (ov && !out_ready && stall_m < CMAX) stall_m++;
         if (flush && flush_m < CMAX) flush_m++;
         if (flush) mq.delete();
         else begin
            if (of) void'(mq.pop_front());
            if (inf) mq.push_back(in_data);
         end
      end
      #1;
      if (!reset) begin
         chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
         chk("m_out_data", out_data, (mq.size() > 0) ? mq[0] : 64'd0);
         chk("m_occupancy", 64'(occupancy), 64'(mq.size()));
         chk("m_in_ready", 64'(in_ready), 64'(mq.size() < 2));
`ifdef PIPE_STAGE_STATS_EN
         chk("m_stall_cnt", 64'(stall_cnt), 64'(stall_m));
         chk("m_flush_cnt", 64'(flush_cnt), 64'(flush_m));
`endif
      end
   end

   task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      // Reset and idle
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_occ", 64'(occupancy), 64'd0);
      reset = 1'b0;
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      chk("idle_occ", 64'(occupancy), 64'd0);

      // Stream 1..8 at full rate
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i > 1) begin
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_data", out_data, 64'(i - 1));
         end
         chk("stream_in_ready", 64'(in_ready), 64'd1);
         in_valid = 1'b1; in_data = 64'(i); out_ready = 1'b1;
      end
      @(negedge clk);
      chk("stream_last", out_data, 64'd8);
      in_valid = 1'b0;
      @(negedge clk);
      chk("stream_drained", 64'(out_valid), 64'd0);

      // Backpressure: A and B held, a junk beat offered while full is ignored
      drive(1, 64'hAAAA, 0, 0);
      drive(1, 64'hBBBB, 0, 0);
      drive(1, 64'hDEAD, 0, 0);
      chk("bp_occ2", 64'(occupancy), 64'd2);
      chk("bp_in_ready0", 64'(in_ready), 64'd0);
      chk("bp_hold_A", out_data, 64'hAAAA);
      drive(0, 0, 1, 0);
      chk("bp_still_A", out_data, 64'hAAAA);
      chk("bp_still_occ2", 64'(occupancy), 64'd2);
      drive(0, 0, 1, 0);
      chk("bp_out_B", out_data, 64'hBBBB);
      chk("bp_in_ready1", 64'(in_ready), 64'd1);
      chk("bp_occ1", 64'(occupancy), 64'd1);
      drive(0, 0, 1, 0);
      chk("bp_empty", 64'(out_valid), 64'd0);

      // Flush while FULL; beat C offered during the flush never appears
      drive(1, 64'h11, 0, 0);
      drive(1, 64'h22, 0, 0);
      drive(1, 64'hCCCC, 0, 1);
      chk("fl_pre_occ2", 64'(occupancy), 64'd2);
      drive(0, 0, 1, 0);
      chk("fl_occ0", 64'(occupancy), 64'd0);
      chk("fl_out_valid0", 64'(out_valid), 64'd0);
      chk("fl_out_data0", out_data, 64'd0);
      chk("fl_in_ready1", 64'(in_ready), 64'd1);
      drive(0, 0, 1, 0);
      chk("fl_no_C", 64'(out_valid), 64'd0);

      // Flush in BUSY that also takes an in_fire: the new beat is discarded
      drive(1, 64'h33, 0, 0);
      drive(1, 64'h44, 0, 1);
      drive(0, 0, 1, 0);
      chk("fl_busy_occ0", 64'(occupancy), 64'd0);
      // Flush together with out_fire: the beat is delivered and nothing remains
      drive(1, 64'h55, 1, 0);
      drive(0, 0, 1, 1);
      chk("flo_data_55", out_data, 64'h55);
      drive(0, 0, 1, 0);
      chk("flo_occ0", 64'(occupancy), 64'd0);

      // Async reset mid-stream clears the outputs before the next edge
      drive(1, 64'h66, 0, 0);
      drive(1, 64'h77, 0, 0);
      drive(0, 0, 0, 0);
      #2 reset = 1'b1;
      #1;
      chk("ar_out_valid", 64'(out_valid), 64'd0);
      chk("ar_out_data", out_data, 64'd0);
      chk("ar_occ", 64'(occupancy), 64'd0);
      chk("ar_in_ready", 64'(in_ready), 64'd1);
`ifdef PIPE_STAGE_STATS_EN
      chk("ar_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("ar_flush_cnt", 64'(flush_cnt), 64'd0);
`endif
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

`ifdef PIPE_STAGE_STATS_EN
      // 5 stall cycles followed by 2 flush cycles
      do_reset();
      drive(1, 64'h88, 0, 0);
      drive(0, 0, 0, 0);
      repeat (4) @(negedge clk);
      drive(0, 0, 1, 1);
      drive(0, 0, 1, 1);
      drive(0, 0, 1, 0);
      chk("st_stall5", 64'(stall_cnt), 64'd5);
      chk("st_flush2", 64'(flush_cnt), 64'd2);

      // Saturation: 20 stall cycles with a 4-bit counter
      do_reset();
      drive(1, 64'h99, 0, 0);
      drive(0, 0, 0, 0);
      repeat (20) @(negedge clk);
      chk("sat_stall15", 64'(stall_cnt), 64'd15);
      drive(0, 0, 1, 0);
`endif

      drive(0, 0, 0, 0);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: simulation did not complete, limit reached at %0t", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end
endmodule
